// File: rtl/cpld_rom_pkg.sv
// Shared constants and types for the CPC multi-slot ROM board controller.
// Config bit positions, bus region codes and write-FSM states.
package cpld_rom_pkg;

  localparam int CFG_EN = 0;
  localparam int CFG_WE = 1;
  localparam int CFG_LO = 2;

  localparam logic [1:0] A_UPPER = 2'b11;
  localparam logic [1:0] A_LOWER = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD
  } wr_state_e;

  function automatic int bank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpld_io_wr_detect.sv
// Two-flop strobe sync plus one-shot Z80 I/O write detect.
// Re-arms only once IOREQ_B has been seen high again.
module cpld_io_wr_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic iorq_b_i,
  input  logic wr_b_i,
  input  logic m1_b_i,
  output logic iowr_o,
  output logic wr_b_s_o
);

  logic [1:0] iorq_q, wr_q, m1_q;
  logic       armed_q, armed_d;
  logic       fire;

  assign fire = armed_q & ~iorq_q[1]
              & ~wr_q[1] & m1_q[1];

  always_comb begin
    armed_d = armed_q;
    if (iorq_q[1])
      armed_d = 1'b1;
    else if (fire)
      armed_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      iorq_q  <= 2'b11;
      wr_q    <= 2'b11;
      m1_q    <= 2'b11;
      armed_q <= 1'b1;
    end else begin
      iorq_q  <= {iorq_q[0], iorq_b_i};
      wr_q    <= {wr_q[0], wr_b_i};
      m1_q    <= {m1_q[0], m1_b_i};
      armed_q <= armed_d;
    end
  end

  assign iowr_o   = fire;
  assign wr_b_s_o = wr_q[1];

endmodule

// File: rtl/cpld_rom_ctrl.sv
// CPC ROM board glue: upper-ROM select latch, slot decode, config
// register and timed SRAM write strobe sequencer.
module cpld_rom_ctrl
  import cpld_rom_pkg::*;
#(
  parameter int          NUM_SLOTS = 16,
  parameter int          BASE_SLOT = 0,
  parameter int          LOWER_EN  = 1,
  parameter logic [15:0] CFG_ADDR  = 16'hDF80,
  parameter int          WE_CYCLES = 2
) (
  input  logic                       CLK,
  input  logic                       RESET_B,
  input  logic [15:0]                A,
  input  logic [7:0]                 D,
  input  logic                       IOREQ_B,
  input  logic                       MREQ_B,
  input  logic                       RD_B,
  input  logic                       WR_B,
  input  logic                       M1_B,
  input  logic                       ROMEN_B,
  output logic                       romdis,
  output logic                       bufoe_b,
  output logic                       bufdir,
  output logic                       rom_ce_b,
  output logic                       rom_oe_b,
  output logic                       rom_we_b,
  output logic [bank_w(NUM_SLOTS):0] rom_bank
);

  localparam int         BW    = bank_w(NUM_SLOTS);
  localparam logic [7:0] NS8   = 8'(NUM_SLOTS);
  localparam logic [7:0] BASE8 = 8'(BASE_SLOT);
  localparam logic [2:0] WE_M1 = 3'(WE_CYCLES - 1);
  localparam logic       LO_OK = (LOWER_EN != 0);

  logic        iowr, wr_s;
  logic [1:0]  mreq_q;
  logic [7:0]  sel_q, sel_d;
  logic [2:0]  cfg_q, cfg_d;
  wr_state_e   st_q, st_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [BW:0] bank_q, bank_d;
  logic [7:0]  diff;
  logic        uhit, lhit, hit;
  logic [BW:0] hit_bank;

  cpld_io_wr_detect u_iowr (
    .clk_i   (CLK),
    .rst_ni  (RESET_B),
    .iorq_b_i(IOREQ_B),
    .wr_b_i  (WR_B),
    .m1_b_i  (M1_B),
    .iowr_o  (iowr),
    .wr_b_s_o(wr_s)
  );

  // Wrap below BASE_SLOT lands far above NUM_SLOTS and so misses.
  assign diff = sel_q - BASE8;
  assign uhit = cfg_q[CFG_EN] & (diff < NS8)
              & (A[15:14] == A_UPPER);
  assign lhit = LO_OK & cfg_q[CFG_EN] & cfg_q[CFG_LO]
              & (A[15:14] == A_LOWER);
  assign hit  = uhit | lhit;

  always_comb begin
    hit_bank = '0;
    if (lhit)
      hit_bank = {1'b1, {BW{1'b0}}};
    else if (uhit)
      hit_bank = {1'b0, diff[BW-1:0]};
  end

  always_comb begin
    sel_d = sel_q;
    cfg_d = cfg_q;
    if (iowr && !A[13])
      sel_d = D;
    if (iowr && A == CFG_ADDR)
      cfg_d = D[2:0];
  end

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    bank_d   = bank_q;
    bufoe_b  = 1'b1;
    bufdir   = 1'b1;
    rom_ce_b = 1'b1;
    rom_oe_b = 1'b1;
    rom_we_b = 1'b1;
    unique case (st_q)
      ST_IDLE: begin
        if (!ROMEN_B && !RD_B && hit) begin
          rom_ce_b = 1'b0;
          rom_oe_b = 1'b0;
          bufoe_b  = 1'b0;
          bufdir   = 1'b0;
        end
        if (!mreq_q[1] && !wr_s
            && cfg_q[CFG_WE] && hit) begin
          st_d   = ST_SETUP;
          bank_d = hit_bank;
        end
      end
      ST_SETUP: begin
        rom_ce_b = 1'b0;
        bufoe_b  = 1'b0;
        if (wr_s) begin
          st_d = ST_HOLD;
        end else begin
          st_d  = ST_PULSE;
          cnt_d = WE_M1;
        end
      end
      ST_PULSE: begin
        rom_ce_b = 1'b0;
        bufoe_b  = 1'b0;
        rom_we_b = 1'b0;
        if (wr_s || cnt_q == 3'd0)
          st_d = ST_HOLD;
        else
          cnt_d = cnt_q - 3'd1;
      end
      ST_HOLD: begin
        rom_ce_b = 1'b0;
        bufoe_b  = 1'b0;
        if (wr_s)
          st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      mreq_q <= 2'b11;
      sel_q  <= 8'h00;
      cfg_q  <= 3'b001;
      st_q   <= ST_IDLE;
      cnt_q  <= 3'd0;
      bank_q <= '0;
    end else begin
      mreq_q <= {mreq_q[0], MREQ_B};
      sel_q  <= sel_d;
      cfg_q  <= cfg_d;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bank_q <= bank_d;
    end
  end

  assign romdis   = hit;
  assign rom_bank = (st_q == ST_IDLE) ? hit_bank : bank_q;

endmodule

// File: tb/tb_cpld_rom_ctrl.sv
// Bench for cpld_rom_ctrl: two parameterisations on one bus, checked
// every cycle against a bus-level model plus directed literal checks.
module tb_cpld_rom_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_B = 1'b0;
  logic [15:0] A = 16'h4000;
  logic [7:0]  D = 8'h00;
  logic IOREQ_B = 1'b1, MREQ_B = 1'b1, RD_B = 1'b1;
  logic WR_B = 1'b1, M1_B = 1'b1, ROMEN_B = 1'b1;

  logic romdis0, bufoe0, dir0, ce0, oe0, we0;
  logic romdis1, bufoe1, dir1, ce1, oe1, we1;
  logic [4:0] bank0;
  logic [3:0] bank1;

  always #5 CLK = ~CLK;

  cpld_rom_ctrl dut0 (
    .CLK(CLK), .RESET_B(RESET_B), .A(A), .D(D),
    .IOREQ_B(IOREQ_B), .MREQ_B(MREQ_B), .RD_B(RD_B),
    .WR_B(WR_B), .M1_B(M1_B), .ROMEN_B(ROMEN_B),
    .romdis(romdis0), .bufoe_b(bufoe0), .bufdir(dir0),
    .rom_ce_b(ce0), .rom_oe_b(oe0), .rom_we_b(we0),
    .rom_bank(bank0)
  );

  cpld_rom_ctrl #(
    .NUM_SLOTS(8), .BASE_SLOT(4), .LOWER_EN(0),
    .CFG_ADDR(16'hDF80), .WE_CYCLES(3)
  ) dut1 (
    .CLK(CLK), .RESET_B(RESET_B), .A(A), .D(D),
    .IOREQ_B(IOREQ_B), .MREQ_B(MREQ_B), .RD_B(RD_B),
    .WR_B(WR_B), .M1_B(M1_B), .ROMEN_B(ROMEN_B),
    .romdis(romdis1), .bufoe_b(bufoe1), .bufdir(dir1),
    .rom_ce_b(ce1), .rom_oe_b(oe1), .rom_we_b(we1),
    .rom_bank(bank1)
  );

  int tot_cnt = 0;
  int pass_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Per-instance parameters seen by the model
  int NS [2]  = '{16, 8};
  int BASE[2] = '{0, 4};
  int LEN [2] = '{1, 0};
  int WEC [2] = '{2, 3};
  int BWv [2] = '{4, 3};

  // Model state: the DUT sees strobes two clocks late
  typedef struct packed {logic iorq, wr, m1, mreq;} bus_t;
  bus_t v0 = 4'hF, v1 = 4'hF;
  int   m_sel [2] = '{0, 0};
  logic [7:0] m_cfg [2] = '{8'h01, 8'h01};
  int   m_wt  [2] = '{0, 0};
  bit   m_hold[2] = '{0, 0};
  int   m_bank[2] = '{0, 0};
  bit   armed = 1'b1;

  function automatic int dif(input int i);
    return (m_sel[i] - BASE[i]) & 255;
  endfunction
  function automatic bit hu(input int i);
    return m_cfg[i][0] && dif(i) < NS[i] && A[15:14] == 2'b11;
  endfunction
  function automatic bit hl(input int i);
    return m_cfg[i][0] && m_cfg[i][2] && LEN[i] == 1
           && A[15:14] == 2'b00;
  endfunction
  function automatic int cbank(input int i);
    if (hl(i)) return 1 << BWv[i];
    if (hu(i)) return dif(i);
    return 0;
  endfunction

  always @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      m_sel = '{0, 0}; m_cfg = '{8'h01, 8'h01};
      m_wt = '{0, 0}; m_hold = '{0, 0}; m_bank = '{0, 0};
      armed = 1'b1; v0 = 4'hF; v1 = 4'hF;
    end else begin
      bus_t v;
      bit fire;
      v = v1;
      for (int i = 0; i < 2; i++) begin
        if (m_wt[i] == 0) begin
          if (!v.mreq && !v.wr && m_cfg[i][1] && (hu(i) || hl(i))) begin
            m_wt[i] = 1; m_hold[i] = 0; m_bank[i] = cbank(i);
          end
        end else if (m_hold[i]) begin
          if (v.wr) m_wt[i] = 0;
        end else if (v.wr) begin
          m_hold[i] = 1;
        end else begin
          m_wt[i]++;
          if (m_wt[i] > WEC[i] + 1) m_hold[i] = 1;
        end
      end
      fire = armed && !v.iorq && !v.wr && v.m1;
      if (fire && !A[13]) m_sel = '{int'(D), int'(D)};
      if (fire && A == 16'hDF80) m_cfg = '{D, D};
      if (v.iorq) armed = 1'b1;
      else if (fire) armed = 1'b0;
      v1 = v0;
      v0 = '{IOREQ_B, WR_B, M1_B, MREQ_B};
    end
  end

  task automatic cmp_one(input int i, input logic rd, input logic bo,
                         input logic dr, input logic ce, input logic oe,
                         input logic we, input int bk);
    logic e_rd, e_bo, e_dr, e_ce, e_oe, e_we;
    int   e_bk;
    e_rd = hu(i) || hl(i);
    {e_bo, e_dr, e_ce, e_oe, e_we} = 5'b11111;
    e_bk = cbank(i);
    if (m_wt[i] != 0) begin
      e_bo = 0; e_ce = 0; e_bk = m_bank[i];
      if (!m_hold[i] && m_wt[i] >= 2) e_we = 0;
    end else if (!ROMEN_B && !RD_B && e_rd) begin
      e_bo = 0; e_dr = 0; e_ce = 0; e_oe = 0;
    end
    chk($sformatf("d%0d romdis", i), 32'(rd), 32'(e_rd));
    chk($sformatf("d%0d bufoe_b", i), 32'(bo), 32'(e_bo));
    chk($sformatf("d%0d bufdir", i), 32'(dr), 32'(e_dr));
    chk($sformatf("d%0d rom_ce_b", i), 32'(ce), 32'(e_ce));
    chk($sformatf("d%0d rom_oe_b", i), 32'(oe), 32'(e_oe));
    chk($sformatf("d%0d rom_we_b", i), 32'(we), 32'(e_we));
    chk($sformatf("d%0d rom_bank", i), 32'(bk), 32'(e_bk));
  endtask

  always @(negedge CLK) begin
    if (RESET_B) begin
      cmp_one(0, romdis0, bufoe0, dir0, ce0, oe0, we0, int'(bank0));
      cmp_one(1, romdis1, bufoe1, dir1, ce1, oe1, we1, int'(bank1));
    end
  end

  int we_lo0 = 0, we_lo1 = 0, ce_lo0 = 0;
  always @(negedge CLK) begin
    if (!we0) we_lo0++;
    if (!we1) we_lo1++;
    if (!ce0 && oe0) ce_lo0++;
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic io_out(input logic [15:0] ad, input logic [7:0] dt,
                        input int n = 4, input logic m1 = 1'b1);
    A = ad; D = dt; IOREQ_B = 0; WR_B = 0; M1_B = m1;
    repeat (n) tick();
    IOREQ_B = 1; WR_B = 1; M1_B = 1;
    repeat (3) tick();
  endtask

  task automatic rd_begin(input logic [15:0] ad, input logic romen);
    A = ad; MREQ_B = 0; RD_B = 0; ROMEN_B = romen;
    tick();
    @(negedge CLK); #1;
  endtask

  task automatic rd_end();
    tick();
    MREQ_B = 1; RD_B = 1; ROMEN_B = 1;
    repeat (2) tick();
  endtask

  task automatic mem_wr(input logic [15:0] ad, input int n);
    A = ad; D = 8'($urandom); MREQ_B = 0; WR_B = 0;
    repeat (n) tick();
    MREQ_B = 1; WR_B = 1;
    repeat (6) tick();
  endtask

  task automatic wait_ce0();
    int k;
    for (k = 0; k < 10 && ce0; k++) tick();
    chk("write setup reached", 32'(ce0), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("reset romdis", 32'(romdis0), 0);
    chk("reset bufoe_b", 32'(bufoe0), 1);
    chk("reset bufdir", 32'(dir0), 1);
    chk("reset ce/oe/we", {ce0, oe0, we0}, 3'b111);
    chk("reset rom_bank", 32'(bank0), 0);
    RESET_B = 1;
    repeat (2) tick();

    io_out(16'hDF00, 8'd5);
    rd_begin(16'hC000, 0);
    chk("sel5 romdis", 32'(romdis0), 1);
    chk("sel5 rom_bank", 32'(bank0), 5);
    chk("sel5 rom_oe_b", 32'(oe0), 0);
    chk("sel5 bufoe_b", 32'(bufoe0), 0);
    chk("sel5 base4 bank", 32'(bank1), 1);
    rd_end();

    io_out(16'hDF00, 8'd20);
    rd_begin(16'hC000, 0);
    chk("sel20 romdis", 32'(romdis0), 0);
    chk("sel20 bufoe_b", 32'(bufoe0), 1);
    rd_end();

    io_out(16'hDF00, 8'd3);
    rd_begin(16'hC000, 0);
    chk("sel3 base4 wrap romdis", 32'(romdis1), 0);
    chk("sel3 base0 romdis", 32'(romdis0), 1);
    rd_end();

    io_out(16'hDF80, 8'h07);
    rd_begin(16'h0000, 0);
    chk("lower romdis", 32'(romdis0), 1);
    chk("lower rom_bank", 32'(bank0), 16);
    chk("lower LOWER_EN=0 romdis", 32'(romdis1), 0);
    rd_end();

    io_out(16'hDF80, 8'h03);
    rd_begin(16'hC000, 0);
    chk("dual decode bank", 32'(bank0), 3);
    rd_end();

    io_out(16'hDF00, 8'd6);
    we_lo0 = 0; we_lo1 = 0;
    A = 16'hC123; MREQ_B = 0; WR_B = 0;
    wait_ce0();
    chk("setup we_b", 32'(we0), 1);
    chk("setup bufdir", 32'(dir0), 1);
    chk("setup oe_b", 32'(oe0), 1);
    tick();
    chk("pulse we_b", 32'(we0), 0);
    repeat (6) tick();
    chk("hold ce_b", 32'(ce0), 0);
    chk("hold we_b", 32'(we0), 1);
    MREQ_B = 1; WR_B = 1;
    repeat (6) tick();
    chk("we low cycles WE2", we_lo0, 2);
    chk("we low cycles WE3", we_lo1, 3);
    chk("idle after write ce_b", 32'(ce0), 1);

    io_out(16'hDF80, 8'h01);
    we_lo0 = 0; ce_lo0 = 0;
    mem_wr(16'hC123, 6);
    chk("protected we low", we_lo0, 0);
    chk("protected ce low", ce_lo0, 0);

    io_out(16'hDF80, 8'h03);
    we_lo0 = 0; ce_lo0 = 0;
    mem_wr(16'hC123, 1);
    chk("abort we low", we_lo0, 0);
    chk("abort entered setup", 32'(ce_lo0 > 0), 1);

    A = 16'hC123; MREQ_B = 0; WR_B = 0;
    wait_ce0();
    tick();
    chk("pre-reset pulse", 32'(we0), 0);
    #2 RESET_B = 0;
    #1;
    chk("async rst we_b", 32'(we0), 1);
    chk("async rst ce_b", 32'(ce0), 1);
    chk("async rst bufoe/dir/oe", {bufoe0, dir0, oe0}, 3'b111);
    chk("async rst bank", 32'(bank0), 0);
    MREQ_B = 1; WR_B = 1;
    @(posedge CLK); #1 RESET_B = 1;
    repeat (2) tick();
    rd_begin(16'hC000, 0);
    chk("post-reset sel0 romdis", 32'(romdis0), 1);
    chk("post-reset sel0 bank", 32'(bank0), 0);
    rd_end();

    for (int it = 0; it < 400; it++) begin
      int r;
      logic [15:0] ad;
      r = $urandom_range(0, 9);
      case ($urandom_range(0, 2))
        0: ad = 16'hC000 | 16'($urandom_range(0, 16383));
        1: ad = 16'($urandom_range(0, 16383));
        default: ad = 16'h4000 | 16'($urandom_range(0, 32767));
      endcase
      if (r <= 2) begin
        case ($urandom_range(0, 2))
          0: io_out(16'hDF80, 8'($urandom_range(0, 7)),
                    $urandom_range(1, 5), $urandom_range(0, 9) != 0);
          1: io_out(16'($urandom) & 16'hDFFF, 8'($urandom_range(0, 23)),
                    $urandom_range(1, 5), $urandom_range(0, 9) != 0);
          default: io_out(16'($urandom), 8'($urandom),
                          $urandom_range(1, 5), 1'b1);
        endcase
      end else if (r <= 5) begin
        A = ad; MREQ_B = 0; RD_B = 0;
        ROMEN_B = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 3)) tick();
        MREQ_B = 1; RD_B = 1; ROMEN_B = 1;
        tick();
      end else if (r <= 8) begin
        mem_wr(ad, $urandom_range(1, 8));
      end else begin
        repeat ($urandom_range(1, 3)) tick();
      end
    end

    repeat (4) tick();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
